cmp_stream_unit: RTL and testbench

Parametrised, pipelined successor to the ALU compare unit. It performs equality, greater-than and less-than compares, each in signed or unsigned mode, plus running-minimum and running-maximum accumulation over a stream of operands. Operands enter through a valid/ready handshake, and results leave through a valid/ready handshake with back-pressure. The block sits beside the arithmetic, logic and shift units behind the ALU function decoder.

---
 rtl/cmp_stream_unit_pkg.sv | 18 +
 rtl/cmp_stream_unit_core.sv | 26 ++
 rtl/cmp_stream_unit.sv | 147 ++++++++++++++
 tb/tb_cmp_stream_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_stream_unit_pkg.sv
// Shared constants for the streaming compare unit: ALU function codes and
// the small result codes returned by the equality/ordering compares.
package cmp_pkg;

  localparam logic [2:0] FN_NOP  = 3'b000;
  localparam logic [2:0] FN_EQ   = 3'b001;
  localparam logic [2:0] FN_GT   = 3'b010;
  localparam logic [2:0] FN_LT   = 3'b011;
  localparam logic [2:0] FN_RMIN = 3'b100;
  localparam logic [2:0] FN_RMAX = 3'b101;
  localparam logic [2:0] FN_ACLR = 3'b110;
  localparam logic [2:0] FN_RSVD = 3'b111;

  localparam logic [1:0] RES_EQ = 2'd1;
  localparam logic [1:0] RES_GT = 2'd2;
  localparam logic [1:0] RES_LT = 2'd3;

endpackage

// File: rtl/cmp_stream_unit_core.sv
// Combinational magnitude comparator; signed_mode selects two's-complement
// or unsigned interpretation of both operands.
module cmp_core #(
  parameter int IN_DATA_WIDTH = 16
) (
  input  logic [IN_DATA_WIDTH-1:0] x,
  input  logic [IN_DATA_WIDTH-1:0] y,
  input  logic                     signed_mode,
  output logic                     eq,
  output logic                     gt,
  output logic                     lt
);

  // Equality is mode independent; ordering depends on the sign interpretation.
  always_comb begin
    eq = (x == y);
    if (signed_mode) begin
      gt = ($signed(x) > $signed(y));
      lt = ($signed(x) < $signed(y));
    end else begin
      gt = (x > y);
      lt = (x < y);
    end
  end

endmodule

// File: rtl/cmp_stream_unit.sv
// Two-stage pipelined compare / running min-max unit with valid/ready on both
// sides. S1 captures the request, S2 evaluates it and owns the accumulator.
module cmp_stream_unit
  import cmp_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [IN_DATA_WIDTH-1:0]  A,
  input  logic [IN_DATA_WIDTH-1:0]  B,
  input  logic [2:0]                ALU_FUNC,
  input  logic                      SIGNED_MODE,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  output logic                      CMP_Flag,
  input  logic                      OUT_READY
);

  if (OUT_DATA_WIDTH < IN_DATA_WIDTH) begin : g_width_check
    $error("cmp_stream_unit: OUT_DATA_WIDTH must be >= IN_DATA_WIDTH");
  end

  localparam logic [OUT_DATA_WIDTH-1:0] OUT_ZERO = {OUT_DATA_WIDTH{1'b0}};

  logic                      s1_valid_r;
  logic [IN_DATA_WIDTH-1:0]  s1_a_r;
  logic [IN_DATA_WIDTH-1:0]  s1_b_r;
  logic [2:0]                s1_func_r;
  logic                      s1_signed_r;
  logic                      cmp_flag_r;
  logic [OUT_DATA_WIDTH-1:0] cmp_out_r;
  logic [IN_DATA_WIDTH-1:0]  acc_r;
  logic                      acc_valid_r;
  logic                      err_r;

  logic                      s2_ready_s;
  logic                      s1_ready_s;
  logic                      ab_eq_s, ab_gt_s, ab_lt_s;
  logic                      aa_eq_s, aa_gt_s, aa_lt_s;
  logic [OUT_DATA_WIDTH-1:0] result_s;
  logic [IN_DATA_WIDTH-1:0]  acc_next_s;
  logic                      acc_valid_next_s;
  logic                      err_set_s;

  function automatic logic [OUT_DATA_WIDTH-1:0] extend_acc(
    input logic [IN_DATA_WIDTH-1:0] value,
    input logic                     sgn
  );
    if (sgn) begin
      extend_acc = OUT_DATA_WIDTH'($signed(value));
    end else begin
      extend_acc = OUT_DATA_WIDTH'(value);
    end
  endfunction

  assign s2_ready_s = !cmp_flag_r || OUT_READY;
  assign s1_ready_s = !s1_valid_r || s2_ready_s;
  assign IN_READY   = s1_ready_s;
  assign CMP_Flag   = cmp_flag_r;
  assign CMP_OUT    = cmp_out_r;

  cmp_core #(.IN_DATA_WIDTH(IN_DATA_WIDTH)) u_cmp_ab (
    .x(s1_a_r), .y(s1_b_r), .signed_mode(s1_signed_r),
    .eq(ab_eq_s), .gt(ab_gt_s), .lt(ab_lt_s)
  );

  cmp_core #(.IN_DATA_WIDTH(IN_DATA_WIDTH)) u_cmp_acc (
    .x(s1_a_r), .y(acc_r), .signed_mode(s1_signed_r),
    .eq(aa_eq_s), .gt(aa_gt_s), .lt(aa_lt_s)
  );

  // S2 evaluation of the operation currently held in S1; ties keep acc.
  always_comb begin
    result_s         = OUT_ZERO;
    acc_next_s       = acc_r;
    acc_valid_next_s = acc_valid_r;
    err_set_s        = 1'b0;
    case (s1_func_r)
      FN_EQ: result_s = ab_eq_s ? OUT_DATA_WIDTH'(RES_EQ) : OUT_ZERO;
      FN_GT: result_s = ab_gt_s ? OUT_DATA_WIDTH'(RES_GT) : OUT_ZERO;
      FN_LT: result_s = ab_lt_s ? OUT_DATA_WIDTH'(RES_LT) : OUT_ZERO;
      FN_RMIN: begin
        if (!acc_valid_r || (aa_lt_s && !aa_eq_s)) begin
          acc_next_s = s1_a_r;
        end else begin
          acc_next_s = acc_r;
        end
        acc_valid_next_s = 1'b1;
        result_s         = extend_acc(acc_next_s, s1_signed_r);
      end
      FN_RMAX: begin
        if (!acc_valid_r || (aa_gt_s && !aa_eq_s)) begin
          acc_next_s = s1_a_r;
        end else begin
          acc_next_s = acc_r;
        end
        acc_valid_next_s = 1'b1;
        result_s         = extend_acc(acc_next_s, s1_signed_r);
      end
      FN_ACLR: begin
        acc_next_s       = {IN_DATA_WIDTH{1'b0}};
        acc_valid_next_s = 1'b0;
      end
      FN_RSVD: err_set_s = 1'b1;
      default: result_s = OUT_ZERO;
    endcase
  end

  // Pipeline registers: S1 loads on input transfer, S2 and acc advance only when S2 can accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_r  <= 1'b0;
      s1_a_r      <= {IN_DATA_WIDTH{1'b0}};
      s1_b_r      <= {IN_DATA_WIDTH{1'b0}};
      s1_func_r   <= 3'b000;
      s1_signed_r <= 1'b0;
      cmp_flag_r  <= 1'b0;
      cmp_out_r   <= OUT_ZERO;
      acc_r       <= {IN_DATA_WIDTH{1'b0}};
      acc_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (s1_ready_s) begin
        s1_valid_r <= IN_VALID;
        if (IN_VALID) begin
          s1_a_r      <= A;
          s1_b_r      <= B;
          s1_func_r   <= ALU_FUNC;
          s1_signed_r <= SIGNED_MODE;
        end
      end
      if (s2_ready_s) begin
        cmp_flag_r <= s1_valid_r;
        if (s1_valid_r) begin
          cmp_out_r   <= result_s;
          acc_r       <= acc_next_s;
          acc_valid_r <= acc_valid_next_s;
          err_r       <= err_r | err_set_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_unit.sv
// Directed self-checking bench for cmp_stream_unit: compares, accumulation
// stream, back-pressure, reset in flight and the narrow-input configuration.
module tb_cmp_stream_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = 16'h0000, b = 16'h0000;
  logic [2:0]  alu_func = 3'b000;
  logic        signed_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] cmp_out;
  logic        cmp_flag;
  logic        out_ready = 1'b1;

  logic [7:0]  a8 = 8'h00, b8 = 8'h00;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [15:0] cmp_out8;
  logic        cmp_flag8;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        mon_en = 1'b1;

  always #5 clk = ~clk;

  cmp_stream_unit #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(16)) dut (
    .CLK(clk), .RST(rst), .A(a), .B(b), .ALU_FUNC(alu_func),
    .SIGNED_MODE(signed_mode), .IN_VALID(in_valid), .IN_READY(in_ready),
    .CMP_OUT(cmp_out), .CMP_Flag(cmp_flag), .OUT_READY(out_ready)
  );

  cmp_stream_unit #(.IN_DATA_WIDTH(8), .OUT_DATA_WIDTH(16)) dut8 (
    .CLK(clk), .RST(rst), .A(a8), .B(b8), .ALU_FUNC(alu_func),
    .SIGNED_MODE(signed_mode), .IN_VALID(in_valid8), .IN_READY(in_ready8),
    .CMP_OUT(cmp_out8), .CMP_Flag(cmp_flag8), .OUT_READY(1'b1)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && cmp_flag && out_ready) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_result", {16'h0000, cmp_out}, 32'hFFFF_FFFF);
        end else begin
          check_value("result", {16'h0000, cmp_out}, {16'h0000, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // One isolated operation; also verifies the two-edge latency.
  task automatic single_op(input string tag, input logic [2:0] f, input logic s,
                           input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev);
    @(negedge clk);
    alu_func = f; signed_mode = s; a = av; b = bv; in_valid = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_value({tag, "_lat1_flag"}, {31'd0, cmp_flag}, 32'd0);
    @(negedge clk);
    #1 check_value({tag, "_lat2_flag"}, {31'd0, cmp_flag}, 32'd1);
  endtask

  initial begin
    logic [2:0]  sf[6] = '{3'b110, 3'b101, 3'b101, 3'b101, 3'b101, 3'b100};
    logic        ss[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] sa[6] = '{16'h0000, 16'h0003, 16'hFFF9, 16'h000A, 16'h000A, 16'h0004};
    logic [15:0] se[6] = '{16'h0000, 16'h0003, 16'h0003, 16'h000A, 16'h000A, 16'h0004};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("rst_flag", {31'd0, cmp_flag}, 32'd0);
    check_value("rst_out", {16'h0000, cmp_out}, 32'd0);
    check_value("rst_in_ready", {31'd0, in_ready}, 32'd1);

    single_op("eq_5_5", 3'b001, 1'b0, 16'd5, 16'd5, 16'd1);
    single_op("gt_uns", 3'b010, 1'b0, 16'h8000, 16'h0001, 16'd2);
    single_op("gt_sgn", 3'b010, 1'b1, 16'h8000, 16'h0001, 16'd0);
    single_op("lt_sgn", 3'b011, 1'b1, 16'h8000, 16'h0001, 16'd3);

    // Back-to-back accumulation stream at full throughput.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      alu_func = sf[i]; signed_mode = ss[i]; a = sa[i]; b = 16'h0000; in_valid = 1'b1;
      exp_q.push_back(se[i]);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_value("stream_drain", exp_q.size(), 32'd0);

    // Back-pressure: three operations issued against a stalled output.
    @(negedge clk);
    out_ready = 1'b0;
    alu_func = 3'b001; signed_mode = 1'b0; a = 16'd1; b = 16'd1; in_valid = 1'b1;
    exp_q.push_back(16'd1);
    @(posedge clk);
    @(negedge clk);
    alu_func = 3'b010; a = 16'd9; b = 16'd2;
    exp_q.push_back(16'd2);
    @(posedge clk);
    @(negedge clk);
    alu_func = 3'b011; a = 16'd2; b = 16'd9;
    exp_q.push_back(16'd3);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_value("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_value("bp_flag", {31'd0, cmp_flag}, 32'd1);
      check_value("bp_out_hold", {16'h0000, cmp_out}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_value("bp_drain", exp_q.size(), 32'd0);

    // Reset while two RMAX operations are in flight.
    mon_en = 1'b0;
    @(negedge clk);
    alu_func = 3'b101; signed_mode = 1'b0; a = 16'd20; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'd21;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 check_value("rst_mid_flag_pre", {31'd0, cmp_flag}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    check_value("rst_mid_flag", {31'd0, cmp_flag}, 32'd0);
    check_value("rst_mid_out", {16'h0000, cmp_out}, 32'd0);
    check_value("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check_value("rst_no_late", {31'd0, cmp_flag}, 32'd0);
    end
    single_op("rmax_after_rst", 3'b101, 1'b0, 16'd9, 16'd0, 16'd9);

    single_op("reserved", 3'b111, 1'b0, 16'h1234, 16'h1234, 16'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 check_value("idle_flag", {31'd0, cmp_flag}, 32'd0);
    end

    // Narrow-input instance: signed RMIN of 0x80 sign-extends to 16 bits.
    @(negedge clk);
    alu_func = 3'b100; signed_mode = 1'b1; a8 = 8'h80; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    #1 check_value("w8_lat1_flag", {31'd0, cmp_flag8}, 32'd0);
    @(negedge clk);
    #1;
    check_value("w8_flag", {31'd0, cmp_flag8}, 32'd1);
    check_value("w8_out", {16'h0000, cmp_out8}, 32'h0000_FF80);

    repeat (3) @(negedge clk);
    check_value("final_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
